// File: rtl/reduction_sel_ctrl_if.sv
// Configuration bus of the reduction select sequencer: beat handshake,
// start command with run length, and the active selects / status it returns.
interface reduction_sel_ctrl_if #(
  parameter int NUM_MUX = 8,
  parameter int SEL_IN  = 2,
  parameter int CW      = 8
);
  logic                      i_cfg_valid;
  logic                      o_cfg_ready;
  logic [SEL_IN-1:0]         i_cfg_data;
  logic                      i_start;
  logic [CW-1:0]             i_num_cycles;
  logic [NUM_MUX*SEL_IN-1:0] o_sel;
  logic                      o_en;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_cfg_err;
  logic                      o_start_err;

  modport master (
    output i_cfg_valid, i_cfg_data, i_start, i_num_cycles,
    input  o_cfg_ready, o_sel, o_en, o_busy, o_done, o_cfg_err, o_start_err
  );

  modport slave (
    input  i_cfg_valid, i_cfg_data, i_start, i_num_cycles,
    output o_cfg_ready, o_sel, o_en, o_busy, o_done, o_cfg_err, o_start_err
  );
endinterface

// File: rtl/reduction_sel_ctrl.sv
// Double-buffered select sequencer for the reduction mux bank.
// Config beats fill a shadow buffer one mux at a time; a start commits the
// shadow to the active selects and enables the datapath for N cycles, so the
// next pattern can load while the current one runs.
module reduction_sel_ctrl #(
  parameter int NUM_MUX = 8,
  parameter int SEL_IN  = 2,
  parameter int MAX_SEL = 2,
  parameter int CW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  reduction_sel_ctrl_if.slave cfg
);

  localparam int              HALF      = SEL_IN / 2;
  localparam int              BW        = $clog2(NUM_MUX);
  localparam int              SW        = NUM_MUX * SEL_IN;
  localparam logic [BW-1:0]   LAST_BEAT = BW'(NUM_MUX - 1);
  localparam logic [31:0]     MAX_SEL_U = MAX_SEL;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          stateQ;
  logic [CW-1:0]   runCntQ;
  logic [SW-1:0]   shadowQ;
  logic [SW-1:0]   selQ;
  logic [BW-1:0]   beatCntQ;
  logic            cfgReadyQ;
  logic            cfgErrQ;
  logic            enQ;
  logic            busyQ;
  logic            doneQ;
  logic            startErrQ;

  logic            shadowFull;
  logic            beatFire;
  logic            commitD;
  logic [HALF-1:0] lowHalf;
  logic [HALF-1:0] highHalf;
  logic            halfBad;

  assign shadowFull = !cfgReadyQ;
  assign beatFire   = cfg.i_cfg_valid && cfgReadyQ;
  assign commitD    = (stateQ == IDLE) && cfg.i_start && shadowFull;
  assign lowHalf    = cfg.i_cfg_data[HALF-1:0];
  assign highHalf   = cfg.i_cfg_data[SEL_IN-1 -: HALF];
  assign halfBad    = (32'(lowHalf) > MAX_SEL_U) || (32'(highHalf) > MAX_SEL_U);

  // Shadow loading: store each accepted beat, flag out-of-range halves, and mark the buffer full after the last mux
  always_ff @(posedge clk) begin
    if (rst) begin
      shadowQ   <= '0;
      beatCntQ  <= '0;
      cfgReadyQ <= 1'b1;
      cfgErrQ   <= 1'b0;
    end else begin
      if (beatFire) begin
        shadowQ[int'(beatCntQ) * SEL_IN +: SEL_IN] <= cfg.i_cfg_data;
        if (halfBad) begin
          cfgErrQ <= 1'b1;
        end
        if (beatCntQ == LAST_BEAT) begin
          beatCntQ  <= '0;
          cfgReadyQ <= 1'b0;
        end else begin
          beatCntQ <= beatCntQ + BW'(1);
        end
      end else if (commitD) begin
        cfgReadyQ <= 1'b1;
      end
    end
  end

  // Run sequencing: commit on start, count down the run, pulse done, and flag starts that cannot be honoured
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ    <= IDLE;
      runCntQ   <= '0;
      selQ      <= '0;
      enQ       <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      startErrQ <= 1'b0;
    end else begin
      doneQ     <= 1'b0;
      startErrQ <= 1'b0;
      case (stateQ)
        IDLE: begin
          if (cfg.i_start) begin
            if (shadowFull) begin
              selQ  <= shadowQ;
              busyQ <= 1'b1;
              if (cfg.i_num_cycles != '0) begin
                stateQ  <= RUN;
                runCntQ <= cfg.i_num_cycles;
                enQ     <= 1'b1;
              end else begin
                stateQ <= DONE;
                doneQ  <= 1'b1;
              end
            end else begin
              startErrQ <= 1'b1;
            end
          end
        end
        RUN: begin
          startErrQ <= cfg.i_start;
          runCntQ   <= runCntQ - CW'(1);
          if (runCntQ == CW'(1)) begin
            stateQ <= DONE;
            enQ    <= 1'b0;
            doneQ  <= 1'b1;
          end
        end
        DONE: begin
          startErrQ <= cfg.i_start;
          stateQ    <= IDLE;
          busyQ     <= 1'b0;
        end
        default: begin
          stateQ <= IDLE;
          enQ    <= 1'b0;
          busyQ  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg.o_cfg_ready = cfgReadyQ;
  assign cfg.o_sel       = selQ;
  assign cfg.o_en        = enQ;
  assign cfg.o_busy      = busyQ;
  assign cfg.o_done      = doneQ;
  assign cfg.o_cfg_err   = cfgErrQ;
  assign cfg.o_start_err = startErrQ;

endmodule

// File: tb/tb_reduction_sel_ctrl.sv
// Directed bench for reduction_sel_ctrl. Select fields are 4 bits wide so each
// 2-bit half can carry values 0..3, which lets a half exceed MAX_SEL = 2.
module tb_reduction_sel_ctrl;

  localparam int NUM_MUX = 8;
  localparam int SEL_IN  = 4;
  localparam int MAX_SEL = 2;
  localparam int CW      = 8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  reduction_sel_ctrl_if #(.NUM_MUX(NUM_MUX), .SEL_IN(SEL_IN), .CW(CW)) bus ();

  reduction_sel_ctrl #(
    .NUM_MUX(NUM_MUX),
    .SEL_IN (SEL_IN),
    .MAX_SEL(MAX_SEL),
    .CW     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg(bus)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs (same 2-bit value in both halves), step past the edge, then drop valid/start
  task automatic applyStimulus(input logic valid, input logic [1:0] half, input logic start, input logic [CW-1:0] n);
    bus.i_cfg_valid  = valid;
    bus.i_cfg_data   = {half, half};
    bus.i_start      = start;
    bus.i_num_cycles = n;
    @(posedge clk);
    #1;
    bus.i_cfg_valid = 1'b0;
    bus.i_start     = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 2'd0, 1'b0, '0);
  endtask

  task automatic loadBeat(input logic [1:0] half);
    applyStimulus(1'b1, half, 1'b0, '0);
  endtask

  task automatic startRun(input logic [CW-1:0] n);
    applyStimulus(1'b0, 2'd0, 1'b1, n);
  endtask

  initial begin
    logic [1:0] patA [8];
    patA = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    rst              = 1'b1;
    bus.i_cfg_valid  = 1'b0;
    bus.i_cfg_data   = '0;
    bus.i_start      = 1'b0;
    bus.i_num_cycles = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    checkOutput("rst_sel",      bus.o_sel,       32'h0);
    checkOutput("rst_en",       bus.o_en,        32'h0);
    checkOutput("rst_busy",     bus.o_busy,      32'h0);
    checkOutput("rst_done",     bus.o_done,      32'h0);
    checkOutput("rst_cfg_err",  bus.o_cfg_err,   32'h0);
    checkOutput("rst_start_err",bus.o_start_err, 32'h0);
    checkOutput("rst_ready",    bus.o_cfg_ready, 32'h1);
    rst = 1'b0;
    idleCycle();

    // Pattern A, N=3
    for (int i = 0; i < 7; i++) loadBeat(patA[i]);
    checkOutput("a_ready_7beats", bus.o_cfg_ready, 32'h1);
    loadBeat(patA[7]);
    checkOutput("a_ready_full", bus.o_cfg_ready, 32'h0);
    idleCycle();
    checkOutput("a_ready_held", bus.o_cfg_ready, 32'h0);
    checkOutput("a_sel_before", bus.o_sel, 32'h0);
    startRun(8'd3);
    checkOutput("a_sel",        bus.o_sel,       32'h50A50A50);
    checkOutput("a_en_t1",      bus.o_en,        32'h1);
    checkOutput("a_busy_t1",    bus.o_busy,      32'h1);
    checkOutput("a_ready_commit", bus.o_cfg_ready, 32'h1);
    idleCycle();
    checkOutput("a_en_t2",      bus.o_en,        32'h1);
    idleCycle();
    checkOutput("a_en_t3",      bus.o_en,        32'h1);
    checkOutput("a_done_t3",    bus.o_done,      32'h0);
    idleCycle();
    checkOutput("a_en_t4",      bus.o_en,        32'h0);
    checkOutput("a_done_t4",    bus.o_done,      32'h1);
    checkOutput("a_busy_t4",    bus.o_busy,      32'h1);
    idleCycle();
    checkOutput("a_done_t5",    bus.o_done,      32'h0);
    checkOutput("a_busy_t5",    bus.o_busy,      32'h0);
    checkOutput("a_cfg_err",    bus.o_cfg_err,   32'h0);

    // Pattern B (2,2,2,2,1,1,1,1), N=10, load all-3 pattern during the run
    for (int i = 0; i < 8; i++) loadBeat(i < 4 ? 2'd2 : 2'd1);
    startRun(8'd10);
    checkOutput("b_sel",        bus.o_sel,       32'h5555AAAA);
    checkOutput("b_en",         bus.o_en,        32'h1);
    loadBeat(2'd3);
    checkOutput("b_cfg_err_set", bus.o_cfg_err,  32'h1);
    for (int i = 1; i < 8; i++) loadBeat(2'd3);
    checkOutput("b_ready_full", bus.o_cfg_ready, 32'h0);
    checkOutput("b_sel_hold",   bus.o_sel,       32'h5555AAAA);
    checkOutput("b_en_mid",     bus.o_en,        32'h1);
    startRun(8'd1);
    checkOutput("b_start_err_run", bus.o_start_err, 32'h1);
    checkOutput("b_sel_ignored",bus.o_sel,       32'h5555AAAA);
    checkOutput("b_en_last",    bus.o_en,        32'h1);
    idleCycle();
    checkOutput("b_done",       bus.o_done,      32'h1);
    checkOutput("b_en_off",     bus.o_en,        32'h0);
    checkOutput("b_start_err_clr", bus.o_start_err, 32'h0);
    idleCycle();
    checkOutput("b_idle_busy",  bus.o_busy,      32'h0);
    startRun(8'd1);
    checkOutput("c_sel",        bus.o_sel,       32'hFFFFFFFF);
    checkOutput("c_en",         bus.o_en,        32'h1);
    checkOutput("c_start_err",  bus.o_start_err, 32'h0);
    idleCycle();
    checkOutput("c_done",       bus.o_done,      32'h1);
    checkOutput("c_en_off",     bus.o_en,        32'h0);
    idleCycle();
    checkOutput("c_cfg_err_sticky", bus.o_cfg_err, 32'h1);

    // Partial shadow start, then start coincident with final beat
    for (int i = 0; i < 5; i++) loadBeat(2'd1);
    startRun(8'd2);
    checkOutput("p_start_err",  bus.o_start_err, 32'h1);
    checkOutput("p_en",         bus.o_en,        32'h0);
    checkOutput("p_busy",       bus.o_busy,      32'h0);
    checkOutput("p_sel_hold",   bus.o_sel,       32'hFFFFFFFF);
    loadBeat(2'd0);
    checkOutput("p_start_err_clr", bus.o_start_err, 32'h0);
    loadBeat(2'd0);
    applyStimulus(1'b1, 2'd0, 1'b1, 8'd2);
    checkOutput("p_same_cycle_err", bus.o_start_err, 32'h1);
    checkOutput("p_same_cycle_en",  bus.o_en,        32'h0);
    checkOutput("p_ready_full",     bus.o_cfg_ready, 32'h0);
    startRun(8'd2);
    checkOutput("p_sel",        bus.o_sel,       32'h00055555);
    checkOutput("p_en_run",     bus.o_en,        32'h1);
    idleCycle();
    idleCycle();
    checkOutput("p_done",       bus.o_done,      32'h1);
    idleCycle();

    // N=0 run
    for (int i = 0; i < 8; i++) loadBeat(i % 2 == 0 ? 2'd1 : 2'd2);
    startRun(8'd0);
    checkOutput("z_sel",        bus.o_sel,       32'hA5A5A5A5);
    checkOutput("z_en",         bus.o_en,        32'h0);
    checkOutput("z_done",       bus.o_done,      32'h1);
    checkOutput("z_busy",       bus.o_busy,      32'h1);
    idleCycle();
    checkOutput("z_done_clr",   bus.o_done,      32'h0);
    checkOutput("z_en_after",   bus.o_en,        32'h0);
    checkOutput("z_busy_clr",   bus.o_busy,      32'h0);

    // Reset on second RUN cycle with a partial shadow pending
    for (int i = 0; i < 8; i++) loadBeat(2'd2);
    startRun(8'd5);
    checkOutput("r_en_1st",     bus.o_en,        32'h1);
    loadBeat(2'd1);
    checkOutput("r_en_2nd",     bus.o_en,        32'h1);
    rst = 1'b1;
    loadBeat(2'd1);
    rst = 1'b0;
    checkOutput("r_en",         bus.o_en,        32'h0);
    checkOutput("r_sel",        bus.o_sel,       32'h0);
    checkOutput("r_busy",       bus.o_busy,      32'h0);
    checkOutput("r_ready",      bus.o_cfg_ready, 32'h1);
    checkOutput("r_cfg_err",    bus.o_cfg_err,   32'h0);
    for (int i = 0; i < 6; i++) loadBeat(2'd1);
    startRun(8'd2);
    checkOutput("r_partial_reject", bus.o_start_err, 32'h1);
    checkOutput("r_partial_en",     bus.o_en,        32'h0);
    loadBeat(2'd2);
    loadBeat(2'd2);
    startRun(8'd2);
    checkOutput("r_sel_fresh",  bus.o_sel,       32'hAA555555);
    checkOutput("r_en_fresh",   bus.o_en,        32'h1);
    idleCycle();
    idleCycle();
    checkOutput("r_done_fresh", bus.o_done,      32'h1);
    idleCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
